// File: rtl/cpc_exp_mailbox.sv
// cpc_exp_mailbox: I/O responder on the CPC expansion port.
//
// Two byte FIFOs bridge the emulated Z80 and a host stream interface:
//   TX FIFO: CPU -> host, RX FIFO: host -> CPU.
// Register map (cpu_addr[1:0], block selected at BASE_HI:BASE_LO[7:2]):
//   0 R: pop RX head (8'hFF if empty)    W: push TX
//   1 R: status {rx_nempty, tx_full, rx_underflow, tx_overflow, 2'b00, ie_tx, ie_rx}
//     W: control {flush, -, clr_rx_underflow, clr_tx_overflow, -, -, ie_tx, ie_rx}
//   2/3: read 8'hFF, writes ignored
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_addr/cpu_dout            Z80 address and write data
//   cpu_din                      read data, 8'hFF when idle (ANDed into CPU bus)
//   iorq/rd/wr/m1                active-high Z80 bus strobes
//   irq                          registered level interrupt
//   host_rx_data/valid/ready     host -> CPU byte stream
//   host_tx_data/valid/ready     CPU -> host byte stream
module cpc_exp_mailbox #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  BASE_HI    = 8'hFB,
  parameter logic [7:0]  BASE_LO    = 8'hD0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        iorq,
  input  logic        rd,
  input  logic        wr,
  input  logic        m1,
  output logic        irq,
  input  logic [7:0]  host_rx_data,
  input  logic        host_rx_valid,
  output logic        host_rx_ready,
  output logic [7:0]  host_tx_data,
  output logic        host_tx_valid,
  input  logic        host_tx_ready
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  // FIFO storage (contents need no reset; pointers and counts define validity)
  logic [7:0] tx_mem [Depth];
  logic [7:0] rx_mem [Depth];

  ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  cnt_t tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;
  logic tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic irq_q, irq_d;

  // Bus edge detection and read snapshot
  logic       rd_act_q, wr_act_q;
  logic [1:0] rd_idx_q, rd_idx_d;
  logic [7:0] rd_snap_q, rd_snap_d;
  logic       rd_nempty_q, rd_nempty_d;

  logic       sel, rd_act, wr_act, wr_fire, rd_end;
  logic [1:0] idx;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0] status, live_data, rx_head;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       ctrl_wr, flush, data_wr;

  // Decode
  assign sel    = iorq & ~m1 & (cpu_addr[15:8] == BASE_HI) & (cpu_addr[7:2] == BASE_LO[7:2]);
  assign idx    = cpu_addr[1:0];
  assign rd_act = sel & rd;
  assign wr_act = sel & wr;

  // One action per I/O cycle: write acts at its leading edge, read pops at its trailing edge
  assign wr_fire = wr_act & ~wr_act_q;
  assign rd_end  = ~rd_act & rd_act_q;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == cnt_t'(Depth));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == cnt_t'(Depth));

  assign rx_head = rx_mem[rx_rptr_q];
  assign status  = {~rx_empty, tx_full, rx_udf_q, tx_ovf_q, 2'b00, ie_tx_q, ie_rx_q};

  always_comb begin
    live_data = 8'hFF;
    case (idx)
      2'd0:    live_data = rx_empty ? 8'hFF : rx_head;
      2'd1:    live_data = status;
      default: live_data = 8'hFF;
    endcase
  end

  // First read cycle shows live data; the rest of the read shows the value latched then,
  // so a host push or flag change mid-read cannot disturb what the CPU samples.
  always_comb begin
    cpu_din = 8'hFF;
    if (rd_act) begin
      cpu_din = rd_act_q ? rd_snap_q : live_data;
    end
  end

  always_comb begin
    rd_snap_d   = rd_snap_q;
    rd_idx_d    = rd_idx_q;
    rd_nempty_d = rd_nempty_q;
    if (rd_act && !rd_act_q) begin
      rd_snap_d   = live_data;
      rd_idx_d    = idx;
      rd_nempty_d = ~rx_empty;
    end
  end

  // Actions
  assign data_wr = wr_fire & (idx == 2'd0);
  assign ctrl_wr = wr_fire & (idx == 2'd1);
  assign flush   = ctrl_wr & cpu_dout[7];

  assign tx_pop  = ~tx_empty & host_tx_ready;
  // A same-cycle host pop frees the slot a push into a full TX FIFO needs
  assign tx_push = data_wr & (~tx_full | tx_pop);
  assign rx_push = host_rx_valid & ~rx_full;
  // Pop only if the CPU actually saw a byte at read start and it is still there
  assign rx_pop  = rd_end & (rd_idx_q == 2'd0) & rd_nempty_q & ~rx_empty;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + ptr_t'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + ptr_t'(1);
      tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
      if (rx_push) rx_wptr_d = rx_wptr_q + ptr_t'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + ptr_t'(1);
      rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
  end

  always_comb begin
    ie_rx_d  = ie_rx_q;
    ie_tx_d  = ie_tx_q;
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (ctrl_wr) begin
      ie_rx_d = cpu_dout[0];
      ie_tx_d = cpu_dout[1];
      if (cpu_dout[4]) tx_ovf_d = 1'b0;
      if (cpu_dout[5]) rx_udf_d = 1'b0;
    end
    if (data_wr && tx_full && !tx_pop)                    tx_ovf_d = 1'b1;
    if (rd_end && (rd_idx_q == 2'd0) && !rd_nempty_q)    rx_udf_d = 1'b1;
  end

  assign irq_d = (ie_rx_q & ~rx_empty) | (ie_tx_q & tx_empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_cnt_q    <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_cnt_q    <= '0;
      ie_rx_q     <= 1'b0;
      ie_tx_q     <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_udf_q    <= 1'b0;
      irq_q       <= 1'b0;
      rd_act_q    <= 1'b0;
      wr_act_q    <= 1'b0;
      rd_idx_q    <= 2'd0;
      rd_snap_q   <= 8'hFF;
      rd_nempty_q <= 1'b0;
    end else begin
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_cnt_q    <= rx_cnt_d;
      ie_rx_q     <= ie_rx_d;
      ie_tx_q     <= ie_tx_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_udf_q    <= rx_udf_d;
      irq_q       <= irq_d;
      rd_act_q    <= rd_act;
      wr_act_q    <= wr_act;
      rd_idx_q    <= rd_idx_d;
      rd_snap_q   <= rd_snap_d;
      rd_nempty_q <= rd_nempty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= cpu_dout;
    if (rx_push) rx_mem[rx_wptr_q] <= host_rx_data;
  end

  assign irq           = irq_q;
  assign host_rx_ready = ~rx_full;
  assign host_tx_valid = ~tx_empty;
  assign host_tx_data  = tx_mem[tx_rptr_q];

endmodule

// File: tb/tb_cpc_exp_mailbox.sv
// Randomised and directed bench for cpc_exp_mailbox against a queue-based reference model.
module tb_cpc_exp_mailbox;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        iorq = 1'b0, rd = 1'b0, wr = 1'b0, m1 = 1'b0;
  logic        irq;
  logic [7:0]  host_rx_data = 8'h00;
  logic        host_rx_valid = 1'b0;
  logic        host_rx_ready;
  logic [7:0]  host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit m_ie_rx, m_ie_tx, m_ovf, m_udf;

  cpc_exp_mailbox dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_addr      (cpu_addr),
    .cpu_dout      (cpu_dout),
    .cpu_din       (cpu_din),
    .iorq          (iorq),
    .rd            (rd),
    .wr            (wr),
    .m1            (m1),
    .irq           (irq),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_decoded(input logic [15:0] a);
    return (a & 16'hFFFC) == 16'hFBD0;
  endfunction

  function automatic logic [7:0] m_status();
    return {rxq.size() != 0, txq.size() == 16, m_udf, m_ovf, 2'b00, m_ie_tx, m_ie_rx};
  endfunction

  function automatic logic m_irq();
    return (m_ie_rx && rxq.size() != 0) || (m_ie_tx && txq.size() == 0);
  endfunction

  task automatic m_reset();
    txq.delete();
    rxq.delete();
    m_ie_rx = 0; m_ie_tx = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic m_write(input logic [15:0] a, input logic [7:0] d);
    if (m_decoded(a) && !m1) begin
      if (a[1:0] == 2'd0) begin
        if (txq.size() < 16) txq.push_back(d);
        else m_ovf = 1;
      end else if (a[1:0] == 2'd1) begin
        m_ie_rx = d[0];
        m_ie_tx = d[1];
        if (d[4]) m_ovf = 0;
        if (d[5]) m_udf = 0;
        if (d[7]) begin
          txq.delete();
          rxq.delete();
        end
      end
    end
  endtask

  task automatic m_read(input logic [15:0] a, output logic [7:0] v);
    v = 8'hFF;
    if (m_decoded(a) && !m1) begin
      if (a[1:0] == 2'd0) begin
        if (rxq.size() == 0) m_udf = 1;
        else v = rxq.pop_front();
      end else if (a[1:0] == 2'd1) begin
        v = m_status();
      end
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    cpu_addr = a; cpu_dout = d; iorq = 1; wr = 1;
    repeat (hold) tick();
    iorq = 0; wr = 0;
    tick();
    m_write(a, d);
  endtask

  // Returns the first sampled byte and whether it held for the whole read
  task automatic bus_read(input logic [15:0] a, input int hold, output logic [7:0] first,
                          output bit stable);
    cpu_addr = a; iorq = 1; rd = 1;
    #1 first = cpu_din;
    stable = 1;
    repeat (hold) begin
      tick();
      if (cpu_din !== first) stable = 0;
    end
    iorq = 0; rd = 0;
    tick();
    tick();
  endtask

  task automatic host_push(input logic [7:0] d);
    host_rx_data = d; host_rx_valid = 1;
    tick();
    host_rx_valid = 0;
    if (rxq.size() < 16) rxq.push_back(d);
  endtask

  task automatic host_pop_check();
    logic [7:0] e;
    vectors++;
    if (host_tx_valid !== (txq.size() != 0)) begin
      miscompares++;
      $display("FAIL host_tx_valid: got %b want %b", host_tx_valid, txq.size() != 0);
    end
    if (txq.size() != 0) begin
      e = txq.pop_front();
      vectors++;
      if (host_tx_data !== e) begin
        miscompares++;
        $display("FAIL host_tx_data: got %h want %h", host_tx_data, e);
      end
    end
    host_tx_ready = 1;
    tick();
    host_tx_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] v; bit st;
    reset_n = 0;
    #3;
    m_reset();
    vectors++;
    if ({irq, host_tx_valid, host_rx_ready, cpu_din} !== {1'b0, 1'b0, 1'b1, 8'hFF}) begin
      miscompares++;
      $display("FAIL reset_outputs: got irq=%b txv=%b rxr=%b din=%h want 0 0 1 ff",
               irq, host_tx_valid, host_rx_ready, cpu_din);
    end
    tick();
    reset_n = 1;
    tick();
    bus_read(16'hFBD1, 3, v, st);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 00", v);
    end
  endtask

  task automatic test_cpu_write();
    cpu_addr = 16'hFBD0; cpu_dout = 8'h5A; iorq = 1; wr = 1;
    tick();
    vectors++;
    if (host_tx_valid !== 1'b1 || host_tx_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL write_latency: got v=%b d=%h want 1 5a", host_tx_valid, host_tx_data);
    end
    repeat (19) tick();
    iorq = 0; wr = 0;
    tick();
    txq.push_back(8'h5A);
    host_pop_check();
    vectors++;
    if (host_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL write_single_push: got host_tx_valid=%b want 0", host_tx_valid);
    end
  endtask

  task automatic test_host_irq();
    logic [7:0] v, e; bit st;
    bus_write(16'hFBD1, 8'h01, 3);
    tick();
    host_rx_data = 8'hA5; host_rx_valid = 1;
    tick();
    host_rx_valid = 0;
    rxq.push_back(8'hA5);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_registered: got %b want 0", irq);
    end
    tick();
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    bus_read(16'hFBD0, 10, v, st);
    m_read(16'hFBD0, e);
    vectors++;
    if (v !== 8'hA5 || !st) begin
      miscompares++;
      $display("FAIL rx_read: got %h stable=%0d want a5 stable=1", v, st);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall: got %b want 0", irq);
    end
    bus_read(16'hFBD1, 3, v, st);
    vectors++;
    if (v !== 8'h01) begin
      miscompares++;
      $display("FAIL status_after_rx: got %h want 01", v);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v; bit st;
    bus_write(16'hFBD1, 8'h00, 2);
    for (int i = 0; i < 17; i++) bus_write(16'hFBD0, 8'($urandom), 3);
    bus_read(16'hFBD1, 2, v, st);
    vectors++;
    if (v !== 8'h50) begin
      miscompares++;
      $display("FAIL overflow_status: got %h want 50", v);
    end
    bus_write(16'hFBD1, 8'h10, 2);
    bus_read(16'hFBD1, 2, v, st);
    vectors++;
    if (v !== 8'h40) begin
      miscompares++;
      $display("FAIL overflow_clear: got %h want 40", v);
    end
    for (int i = 0; i < 16; i++) host_pop_check();
  endtask

  task automatic test_underflow_decode();
    logic [7:0] v, e; bit st;
    bus_read(16'hFBD0, 4, v, st);
    m_read(16'hFBD0, e);
    vectors++;
    if (v !== 8'hFF || e !== 8'hFF) begin
      miscompares++;
      $display("FAIL underflow_read: got %h want ff", v);
    end
    host_push(8'h3C);
    bus_read(16'hFBD4, 3, v, st);
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL decode_fbd4: got %h want ff", v);
    end
    bus_read(16'hFAD0, 3, v, st);
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL decode_fad0: got %h want ff", v);
    end
    m1 = 1;
    bus_read(16'hFBD0, 3, v, st);
    bus_write(16'hFBD1, 8'h80, 3);
    m1 = 0;
    vectors++;
    if (v !== 8'hFF) begin
      miscompares++;
      $display("FAIL decode_inta: got %h want ff", v);
    end
    bus_write(16'hFAD1, 8'h80, 3);
    bus_write(16'hFBD5, 8'h80, 3);
    bus_read(16'hFBD1, 2, v, st);
    vectors++;
    if (v !== 8'hA0 || m_status() !== 8'hA0) begin
      miscompares++;
      $display("FAIL underflow_status: got %h want a0", v);
    end
    bus_read(16'hFBD0, 3, v, st);
    m_read(16'hFBD0, e);
    vectors++;
    if (v !== 8'h3C) begin
      miscompares++;
      $display("FAIL decode_nochange: got %h want 3c", v);
    end
    bus_write(16'hFBD1, 8'h20, 2);
  endtask

  task automatic test_full_simul();
    logic [7:0] v, e; bit st;
    for (int i = 0; i < 16; i++) bus_write(16'hFBD0, 8'($urandom), 2);
    cpu_addr = 16'hFBD0; cpu_dout = 8'hC7; iorq = 1; wr = 1; host_tx_ready = 1;
    tick();
    host_tx_ready = 0;
    void'(txq.pop_front());
    txq.push_back(8'hC7);
    repeat (3) tick();
    iorq = 0; wr = 0;
    tick();
    bus_read(16'hFBD1, 2, v, st);
    m_read(16'hFBD1, e);
    vectors++;
    if (v !== e) begin
      miscompares++;
      $display("FAIL full_push_pop: got %h want %h", v, e);
    end
    for (int i = 0; i < 16; i++) host_pop_check();
  endtask

  task automatic test_flush_race();
    for (int i = 0; i < 16; i++) host_push(8'($urandom));
    vectors++;
    if (host_rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_full_ready: got %b want 0", host_rx_ready);
    end
    bus_write(16'hFBD0, 8'h11, 2);
    bus_write(16'hFBD0, 8'h22, 2);
    cpu_addr = 16'hFBD1; cpu_dout = 8'h80; iorq = 1; wr = 1; host_tx_ready = 1;
    tick();
    host_tx_ready = 0;
    m_write(16'hFBD1, 8'h80);
    vectors++;
    if (host_tx_valid !== 1'b0 || host_rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_race: got txv=%b rxr=%b want 0 1", host_tx_valid, host_rx_ready);
    end
    repeat (3) tick();
    iorq = 0; wr = 0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] v, e, d; logic [15:0] a; bit st;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: bus_write(16'hFBD0, 8'($urandom), $urandom_range(1, 5));
        1: begin
          bus_read(16'hFBD0, $urandom_range(1, 5), v, st);
          m_read(16'hFBD0, e);
          vectors++;
          if (v !== e || !st) begin
            miscompares++;
            $display("FAIL rand_rx_read: got %h stable=%0d want %h", v, st, e);
          end
        end
        2: begin
          vectors++;
          if (host_rx_ready !== (rxq.size() < 16)) begin
            miscompares++;
            $display("FAIL rand_rx_ready: got %b want %b", host_rx_ready, rxq.size() < 16);
          end
          host_push(8'($urandom));
        end
        3: host_pop_check();
        4: begin
          bus_read(16'hFBD1, $urandom_range(1, 4), v, st);
          m_read(16'hFBD1, e);
          vectors++;
          if (v !== e) begin
            miscompares++;
            $display("FAIL rand_status: got %h want %h", v, e);
          end
        end
        5: begin
          d = 8'($urandom);
          if ($urandom_range(0, 9) != 0) d[7] = 1'b0;
          bus_write(16'hFBD1, d, $urandom_range(1, 4));
        end
        default: begin
          a = 16'($urandom);
          if (m_decoded(a)) a[8] = ~a[8];
          if ($urandom_range(0, 1) == 1) bus_write(a, 8'($urandom), 2);
          else begin
            bus_read(a, 2, v, st);
            vectors++;
            if (v !== 8'hFF) begin
              miscompares++;
              $display("FAIL rand_decode_miss: addr %h got %h want ff", a, v);
            end
          end
        end
      endcase
      tick();
      vectors++;
      if (irq !== m_irq() || host_tx_valid !== (txq.size() != 0) ||
          host_rx_ready !== (rxq.size() < 16)) begin
        miscompares++;
        $display("FAIL rand_outputs: got irq=%b txv=%b rxr=%b want %b %b %b", irq,
                 host_tx_valid, host_rx_ready, m_irq(), txq.size() != 0, rxq.size() < 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v; bit st;
    bus_write(16'hFBD1, 8'h80, 2);
    bus_write(16'hFBD1, 8'h03, 2);
    host_push(8'h77);
    for (int i = 0; i < 3; i++) bus_write(16'hFBD0, 8'($urandom), 2);
    tick();
    vectors++;
    if (irq !== 1'b1 || host_tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got irq=%b txv=%b want 1 1", irq, host_tx_valid);
    end
    host_tx_ready = 0;
    reset_n = 0;
    #3;
    m_reset();
    vectors++;
    if (host_tx_valid !== 1'b0 || irq !== 1'b0 || host_rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got txv=%b irq=%b rxr=%b want 0 0 1", host_tx_valid, irq,
               host_rx_ready);
    end
    tick();
    reset_n = 1;
    tick();
    bus_read(16'hFBD1, 2, v, st);
    vectors++;
    if (v !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_status: got %h want 00", v);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_host_irq();
    test_overflow();
    test_underflow_decode();
    test_full_simul();
    test_flush_race();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
